bit_serializer: RTL

//   Parallel-to-serial front end for the In1 input of the sequence FSM.

---
 rtl/bit_serializer_if.sv | 12 +
 rtl/bit_serializer.sv | 79 +++++++
 2 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake in, serial bit stream with framing flags out
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;
  modport master (output in_data, in_valid, input in_ready, ser_out, ser_valid, word_done, busy);
  modport slave  (input in_data, in_valid, output in_ready, ser_out, ser_valid, word_done, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: buffered parallel-to-serial shifter with optional inter-word gap
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  bit_serializer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_shift;
  logic             r_buf_full;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_word_done;
  logic [CW-1:0]    r_bit_cnt;
  logic [7:0]       r_gap_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_gap_last;
  logic             w_load;
  logic             w_first;
  logic             w_next;
  assign bus.in_ready  = ~r_buf_full;
  assign bus.ser_out   = r_ser_out;
  assign bus.ser_valid = r_ser_valid;
  assign bus.word_done = r_word_done;
  assign bus.busy      = (r_state != IDLE) | r_buf_full;
  assign w_accept   = bus.in_valid & ~r_buf_full;
  assign w_last     = r_bit_cnt == CW'(WIDTH - 1);
  assign w_gap_last = r_gap_cnt == 8'(GAP_CYCLES - 1);
  // the buffer only moves into the shifter when the shifter is free at this edge
  assign w_load = r_buf_full & ((r_state == IDLE) |
                                ((r_state == SHIFT) & w_last & (GAP_CYCLES == 0)) |
                                ((r_state == GAP) & w_gap_last));
  assign w_first = MSB_FIRST ? r_buf[WIDTH-1] : r_buf[0];
  assign w_next  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_shift     <= '0;
      r_buf_full  <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_ser_out   <= IDLE_BIT;
      r_ser_valid <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_buf_full <= w_accept | (r_buf_full & ~w_load);
      if (w_accept) r_buf <= bus.in_data;
      if (w_load) begin
        r_state     <= SHIFT;
        r_shift     <= r_buf;
        r_bit_cnt   <= '0;
        r_ser_out   <= w_first;
        r_ser_valid <= 1'b1;
        r_word_done <= 1'b0;
      end else if (r_state == SHIFT && !w_last) begin
        r_shift     <= MSB_FIRST ? r_shift << 1 : r_shift >> 1;
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        r_ser_out   <= w_next;
        r_word_done <= r_bit_cnt == CW'(WIDTH - 2);
      end else if (r_state == SHIFT || (r_state == GAP && w_gap_last)) begin
        r_state     <= (r_state == SHIFT && GAP_CYCLES > 0) ? GAP : IDLE;
        r_gap_cnt   <= '0;
        r_ser_out   <= IDLE_BIT;
        r_ser_valid <= 1'b0;
        r_word_done <= 1'b0;
      end else if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
endmodule
